// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the decode control bundle and helpers used by the ID/EX stage.
package pipeline_pkg;

    localparam int CTRL_W  = 9;
    localparam int ALUOP_W = 4;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
        logic branch;
        logic jump;
        logic link;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

    // rt is a real source unless the immediate replaces it; stores still read rt as data.
    function automatic logic uses_rt(input logic alu_src, input logic mem_write);
        return !alu_src || mem_write;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decode-side operands and controls in, WB bypass, flush, stall and EX-side register out.
interface id_ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 4
);
    import pipeline_pkg::*;

    logic               id_valid;
    logic [DATA_W-1:0]  id_pc_plus4;
    logic [ADDR_W-1:0]  id_rs;
    logic [ADDR_W-1:0]  id_rt;
    logic [ADDR_W-1:0]  id_rd;
    logic [DATA_W-1:0]  id_data_a;
    logic [DATA_W-1:0]  id_data_b;
    logic [DATA_W-1:0]  id_imm;
    ctrl_t              id_ctrl;
    logic [ALUOP_W-1:0] id_alu_op;
    logic               wb_reg_write;
    logic [ADDR_W-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               flush;
    logic               stall;
    logic               ex_valid;
    logic [DATA_W-1:0]  ex_pc_plus4;
    logic [DATA_W-1:0]  ex_data_a;
    logic [DATA_W-1:0]  ex_data_b;
    logic [DATA_W-1:0]  ex_imm;
    logic [ADDR_W-1:0]  ex_rs;
    logic [ADDR_W-1:0]  ex_rt;
    logic [ADDR_W-1:0]  ex_rd;
    ctrl_t              ex_ctrl;
    logic [ALUOP_W-1:0] ex_alu_op;

    modport master (
        output id_valid, id_pc_plus4, id_rs, id_rt, id_rd, id_data_a, id_data_b, id_imm,
               id_ctrl, id_alu_op, wb_reg_write, wb_addr, wb_data, flush,
        input  stall, ex_valid, ex_pc_plus4, ex_data_a, ex_data_b, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_ctrl, ex_alu_op
    );

    modport slave (
        input  id_valid, id_pc_plus4, id_rs, id_rt, id_rd, id_data_a, id_data_b, id_imm,
               id_ctrl, id_alu_op, wb_reg_write, wb_addr, wb_data, flush,
        output stall, ex_valid, ex_pc_plus4, ex_data_a, ex_data_b, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_ctrl, ex_alu_op
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_alu_src,
    input  logic              id_mem_write,
    input  logic              flush,
    output logic              hz,
    output logic              stall
);

    assign hz = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
                ((ex_rt == id_rs) ||
                 ((ex_rt == id_rt) && uses_rt(id_alu_src, id_mem_write)));

    // A killed instruction in ID cannot consume the load, so flush cancels the stall.
    assign stall = hz && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB-to-ID bypass, load-use bubble insertion and flush.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    logic              hz;
    logic              stall;
    logic [ADDR_W-1:0] src_addr [2];
    logic [DATA_W-1:0] src_data [2];
    logic [DATA_W-1:0] op       [2];

    assign src_addr[0] = bus.id_rs;
    assign src_addr[1] = bus.id_rt;
    assign src_data[0] = bus.id_data_a;
    assign src_data[1] = bus.id_data_b;

    // The register file does not forward, so a same-cycle WB write must be picked up here.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign op[gi] = (bus.wb_reg_write && (bus.wb_addr == src_addr[gi]) &&
                             (src_addr[gi] != REG_ZERO)) ? bus.wb_data : src_data[gi];
        end
    endgenerate

    hazard_detect #(.ADDR_W(ADDR_W)) u_hazard_detect (
        .ex_valid     (bus.ex_valid),
        .ex_mem_read  (bus.ex_ctrl.mem_read),
        .ex_rt        (bus.ex_rt),
        .id_valid     (bus.id_valid),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_alu_src   (bus.id_ctrl.alu_src),
        .id_mem_write (bus.id_ctrl.mem_write),
        .flush        (bus.flush),
        .hz           (hz),
        .stall        (stall)
    );

    assign bus.stall = stall;

    logic              ex_valid_next;
    logic [DATA_W-1:0] ex_pc_plus4_next;
    logic [DATA_W-1:0] ex_data_a_next;
    logic [DATA_W-1:0] ex_data_b_next;
    logic [DATA_W-1:0] ex_imm_next;
    logic [ADDR_W-1:0] ex_rs_next;
    logic [ADDR_W-1:0] ex_rt_next;
    logic [ADDR_W-1:0] ex_rd_next;
    ctrl_t             ex_ctrl_next;
    logic [ALUOP_W-1:0] ex_alu_op_next;

    // Flush, hazard and an empty decode slot all produce the same all-zero bubble.
    always_comb begin
        ex_valid_next    = 1'b0;
        ex_pc_plus4_next = '0;
        ex_data_a_next   = '0;
        ex_data_b_next   = '0;
        ex_imm_next      = '0;
        ex_rs_next       = '0;
        ex_rt_next       = '0;
        ex_rd_next       = '0;
        ex_ctrl_next     = BUBBLE_CTRL;
        ex_alu_op_next   = '0;
        if (!bus.flush && !hz && bus.id_valid) begin
            ex_valid_next    = 1'b1;
            ex_pc_plus4_next = bus.id_pc_plus4;
            ex_data_a_next   = op[0];
            ex_data_b_next   = op[1];
            ex_imm_next      = bus.id_imm;
            ex_rs_next       = bus.id_rs;
            ex_rt_next       = bus.id_rt;
            ex_rd_next       = bus.id_rd;
            ex_ctrl_next     = bus.id_ctrl;
            ex_alu_op_next   = bus.id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc_plus4 <= '0;
            bus.ex_data_a   <= '0;
            bus.ex_data_b   <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rs       <= '0;
            bus.ex_rt       <= '0;
            bus.ex_rd       <= '0;
            bus.ex_ctrl     <= BUBBLE_CTRL;
            bus.ex_alu_op   <= '0;
        end else begin
            bus.ex_valid    <= ex_valid_next;
            bus.ex_pc_plus4 <= ex_pc_plus4_next;
            bus.ex_data_a   <= ex_data_a_next;
            bus.ex_data_b   <= ex_data_b_next;
            bus.ex_imm      <= ex_imm_next;
            bus.ex_rs       <= ex_rs_next;
            bus.ex_rt       <= ex_rt_next;
            bus.ex_rd       <= ex_rd_next;
            bus.ex_ctrl     <= ex_ctrl_next;
            bus.ex_alu_op   <= ex_alu_op_next;
        end
    end

endmodule
